// File: rtl/reg_read_pkg.sv
// Shared constants and types for the register read port.
// Build option: REG_READ_ZERO_REG_EN makes the top index read as zero.
package reg_read_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_DEPTH = 32;
  localparam int unsigned ZERO_IDX  = DEF_DEPTH - 1;

  typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_read_mux.sv
// Parametrised DEPTH:1 word mux built as a recursive 2:1 tree.
// The top select bit picks between two half-size sub-trees.
module reg_read_mux
  import reg_read_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned SEL_W = $clog2(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       dout
);

  if (DEPTH == 2) begin : g_leaf
    // Final 2:1 stage on the lowest select bit.
    always_comb begin
      dout = sel[0] ? din[WIDTH +: WIDTH] : din[0 +: WIDTH];
    end
  end else begin : g_node
    localparam int unsigned HALF = DEPTH / 2;

    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    reg_read_mux #(
      .WIDTH (WIDTH),
      .DEPTH (HALF),
      .SEL_W (SEL_W - 1)
    ) u_lo (
      .din  (din[0 +: HALF*WIDTH]),
      .sel  (sel[SEL_W-2:0]),
      .dout (lo)
    );

    reg_read_mux #(
      .WIDTH (WIDTH),
      .DEPTH (HALF),
      .SEL_W (SEL_W - 1)
    ) u_hi (
      .din  (din[HALF*WIDTH +: HALF*WIDTH]),
      .sel  (sel[SEL_W-2:0]),
      .dout (hi)
    );

    // Top select bit chooses the upper or lower half.
    always_comb begin
      dout = sel[SEL_W-1] ? hi : lo;
    end
  end

endmodule

// File: rtl/reg_read_port.sv
// One-cycle registered read port with write bypass and output stall.
// Build option: REG_READ_ZERO_REG_EN forces index DEPTH-1 to read 0.
module reg_read_port
  import reg_read_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned SEL_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DEPTH*WIDTH-1:0] entries,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SEL_W-1:0]       req_sel,
  input  logic                   wr_en,
  input  logic [SEL_W-1:0]       wr_sel,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data
);

  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] rd_data;
  logic             out_valid_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_d;
  logic [WIDTH-1:0] out_data_q;

  reg_read_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_mux (
    .din  (entries),
    .sel  (req_sel),
    .dout (mux_data)
  );

`ifdef REG_READ_ZERO_REG_EN
  localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(DEPTH - 1);

  // Zero index wins over both the array and the bypass.
  always_comb begin
    rd_data = mux_data;
    if (req_sel == ZERO_SEL) begin
      rd_data = '0;
    end else if (wr_en && (wr_sel == req_sel)) begin
      rd_data = wr_data;
    end
  end
`else
  // Same-cycle write to the selected entry is forwarded.
  always_comb begin
    rd_data = mux_data;
    if (wr_en && (wr_sel == req_sel)) begin
      rd_data = wr_data;
    end
  end
`endif

  // Output slot is free when empty or being drained.
  always_comb begin
    req_ready = !out_valid_q || out_ready;
  end

  // Load on accept, clear on drain, hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (req_ready) begin
      out_valid_d = req_valid;
      if (req_valid) begin
        out_data_d = rd_data;
      end
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_reg_read_port.sv
// Scoreboard bench for reg_read_port with random and directed traffic.
// Expected words come from a behavioural model of the register array.
module tb_reg_read_port;

  localparam int W  = 64;
  localparam int D  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  ent [D];
  logic [D*W-1:0] entries;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_sel;
  logic          wr_en;
  logic [SW-1:0] wr_sel;
  logic [W-1:0]  wr_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  logic [W-1:0]  sb [$];
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < D; i++) entries[i*W +: W] = ent[i];
  end

  reg_read_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .entries   (entries),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input int sel, input bit we,
                                         input int ws,
                                         input logic [W-1:0] wd);
`ifdef REG_READ_ZERO_REG_EN
    if (sel == D - 1) return '0;
`endif
    if (we && ws == sel) return wd;
    return ent[sel];
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: compare every presented result against the queue front.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", W'(req_ready), W'(!out_valid || out_ready));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", W'(out_valid), '0);
        end else begin
          chk("out_data", out_data, sb[0]);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Drive one cycle of request; push the model answer if accepted.
  task automatic issue(input bit v, input int sel, input bit we,
                       input int ws, input logic [W-1:0] wd);
    logic [W-1:0] e;
    bit rdy;
    req_valid = v;
    req_sel   = SW'(sel);
    wr_en     = we;
    wr_sel    = SW'(ws);
    wr_data   = wd;
    @(negedge clk);
    rdy = req_ready;
    e   = model(sel, we, ws, wd);
    @(posedge clk);
    if (v && rdy) sb.push_back(e);
    #1;
  endtask

  initial begin
    req_valid = 0;
    req_sel   = '0;
    wr_en     = 0;
    wr_sel    = '0;
    wr_data   = '0;
    out_ready = 0;
    for (int i = 0; i < D; i++) ent[i] = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_ready", W'(req_ready), W'(1));

    ent[5]    = 64'h55;
    out_ready = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 5, 0, 0, '0);
    #2;
    chk("first_valid", W'(out_valid), W'(1));
    chk("first_data", out_data, 64'h55);

    for (int i = 0; i < D; i++) ent[i] = W'(i * 32'h0101);
    for (int i = 0; i < D; i++) begin
      issue(1, i, 0, 0, '0);
      #2;
      chk("no_bubble", W'(out_valid), W'(1));
    end
    issue(0, 0, 0, 0, '0);

    issue(1, 7, 0, 0, '0);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      ent[7] = rnd64();
      issue(1, 3, 1, 7, rnd64());
      #2;
      chk("stall_valid", W'(out_valid), W'(1));
      chk("stall_ready", W'(req_ready), '0);
      chk("stall_data", out_data, 64'h0707);
    end
    out_ready = 1;
    issue(0, 0, 0, 0, '0);

    ent[9] = 64'h1;
    issue(1, 9, 1, 9, 64'hDEAD);
    #2 chk("bypass_hit", out_data, 64'hDEAD);
    issue(1, 9, 1, 10, 64'hBEEF);
    #2 chk("bypass_miss", out_data, 64'h1);

    ent[31] = 64'hFFFF;
    issue(1, 31, 0, 0, '0);
`ifdef REG_READ_ZERO_REG_EN
    #2 chk("zero_reg", out_data, '0);
`else
    #2 chk("zero_reg", out_data, 64'hFFFF);
`endif
    issue(1, 31, 1, 31, 64'h1234);
`ifdef REG_READ_ZERO_REG_EN
    #2 chk("zero_bypass", out_data, '0);
`else
    #2 chk("zero_bypass", out_data, 64'h1234);
`endif
    issue(0, 0, 0, 0, '0);

    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 2) ent[$urandom % D] = rnd64();
      issue(($urandom % 4) != 0, int'($urandom % D), bit'($urandom % 2),
            int'($urandom % D), rnd64());
    end
    out_ready = 1;
    issue(0, 0, 0, 0, '0);
    issue(0, 0, 0, 0, '0);

    ent[12] = 64'hC0FFEE;
    issue(1, 12, 0, 0, '0);
    out_ready = 0;
    issue(0, 0, 0, 0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall_valid", W'(out_valid), '0);
    chk("rst_stall_data", out_data, '0);
    chk("rst_stall_ready", W'(req_ready), W'(1));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, 0, 0, '0);
      chk("no_stale", W'(out_valid), '0);
    end
    out_ready = 1;
    ent[2] = 64'hA5A5;
    issue(1, 2, 0, 0, '0);
    #2 chk("post_rst_read", out_data, 64'hA5A5);

    for (int i = 0; i < 20 && sb.size() != 0; i++) issue(0, 0, 0, 0, '0);
    if (sb.size() != 0) chk("drain_timeout", W'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_read_port.md
REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 Parameter WIDTH, default 64: data bits per register entry.
REQ-002 Parameter DEPTH, default 32: number of entries; a power of two, at least 2.
REQ-003 Parameter SEL_W, default $clog2(DEPTH): select width.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-005 Port list, in order:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- entries  input  DEPTH*WIDTH  flattened register contents; entry i occupies bits [i*WIDTH +: WIDTH].
- req_valid  input  1  read request present.
- req_ready  output  1  request accepted this cycle.
- req_sel  input  SEL_W  index of the entry to read.
- wr_en  input  1  same-cycle register write, used for bypass.
- wr_sel  input  SEL_W  write index.
- wr_data  input  WIDTH  write data.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  read result.

Function
REQ-006 A request is accepted on a rising edge where req_valid && req_ready.
REQ-007 req_ready = !out_valid || out_ready; this is combinational, with no dependency on req_valid.
REQ-008 Latency SHALL be one cycle: a request accepted at edge N is shown as out_valid=1 with its data after edge N.
REQ-009 Captured data = entries[req_sel] sampled at the accept edge.
REQ-010 Bypass: if wr_en && wr_sel==req_sel at the accept edge, wr_data is captured instead of entries[req_sel].
REQ-011 Stall: while out_valid && !out_ready, out_valid and out_data SHALL hold stable. No request is accepted during a stall.
REQ-012 Simultaneous accept and drain (out_valid && out_ready && req_valid): out_data is replaced at the same edge, with no bubble cycle.
REQ-013 Drain without a new request: out_valid falls to 0 at that edge; out_data holds its last value.
REQ-014 The select SHALL be used modulo DEPTH. With no aliasing, all SEL_W bits are significant.
REQ-015 Changes on entries or wr_* while stalled SHALL NOT alter the held out_data.

Reset
REQ-016 rst_n low SHALL force out_valid=0 and out_data=0 immediately, independent of clk.
REQ-017 Reset mid-stall SHALL discard the held result; after release, req_ready=1.
REQ-018 Release is synchronous to clk; the first accept is possible at the first edge with rst_n high.

Configuration
REQ-019 Macro REG_READ_ZERO_REG_EN SHALL select zero-register behaviour.
- Defined: index DEPTH-1 always reads 0 and the bypass for that index is suppressed.
- Undefined: index DEPTH-1 is an ordinary entry.

Structure
REQ-020 Package reg_read_pkg SHALL hold:
- default WIDTH and DEPTH constants;
- the ZERO_IDX constant (DEPTH-1);
- a typedef for the WIDTH-bit data word.
REQ-021 One sub-module, reg_read_mux: a parametrised combinational DEPTH:1 mux of WIDTH bits.
- Built as a recursive binary tree of 2:1 stages.
- Instantiated once, feeding the bypass and zero logic ahead of the output register.

Verification
REQ-022 Reset and first read:
- rst_n low: out_valid=0, out_data=0, req_ready=1.
- Release, then request sel=5 with entries[5]=0x55: next cycle out_valid=1, out_data=0x55.
REQ-023 Back-to-back reads:
- Sweep sel=0..31 with out_ready=1 and entries[i]=i*0x0101.
- Expect 32 consecutive results in order, no bubbles.
REQ-024 Stall:
- Hold out_ready=0 for 3 cycles after a read of sel=7.
- Expect out_data stable and req_ready=0 throughout, even when entries[7] changes.
REQ-025 Bypass:
- Request sel=9 together with wr_en=1, wr_sel=9, wr_data=0xDEAD, with entries[9]=0x1.
- Expect out_data=0xDEAD.
- Repeat with wr_sel=10: expect out_data=0x1.
REQ-026 Zero register:
- Set entries[31]=0xFFFF and request sel=31.
- Expect 0 with REG_READ_ZERO_REG_EN defined, 0xFFFF without it.
- Bypass to index 31 is ignored when the macro is defined.
REQ-027 Reset mid-stall:
- Assert rst_n low while out_valid=1 and out_ready=0.
- Expect out_valid=0 asynchronously, and after release no stale result reappears.
